idct_row_accum: RTL and testbench
=================================

IDCT_ROW_ACCUM -- requirements
Module: idct_row_accum

Interface
REQ-001 Parameter ACC_LEN, 8: number of products summed per output sample; power of two, range 2..16.
REQ-002 Parameter OUT_BITWIDTH, 16: signed width of each output sample.
REQ-003 Parameter SHIFT, 16: right-shift applied to the accumulated sum before the output.
REQ-004 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-005 Port racc  input  1: reset, asynchronous, active-high.
REQ-006 Port P  input  32: signed product word from the multiplier-wrapper stage.
REQ-007 Port p_valid  input  1: P holds a product to consume this cycle.
REQ-008 Port rapx  input  1: approximate mode; when 1, P[7:0] is forced to 0 before accumulation.
REQ-009 Port flush  input  1: synchronous discard of the partial sum and term count.
REQ-010 Port in_ready  output  1: block accepts a product this cycle.
REQ-011 Port out_data  output  OUT_BITWIDTH: head result of the output buffer, signed.
REQ-012 Port out_valid  output  1: out_data is valid.
REQ-013 Port out_ready  input  1: downstream consumes out_data when out_valid is also 1.
REQ-014 Port term_cnt  output  log2(ACC_LEN)+1: number of terms in the current partial sum.
REQ-015 Port sat_flag  output  1: sticky flag; set when any output sample saturated.

Function
REQ-016 The accumulator SHALL be signed, 32+log2(ACC_LEN)+1 bits wide, and SHALL add the sign-extended, rapx-masked P on each accepted product.
REQ-017 A product SHALL be accepted when p_valid and in_ready are both 1; otherwise P SHALL be ignored.
REQ-018 in_ready SHALL be 1 exactly when the output buffer holds fewer than 2 entries; it SHALL be a registered signal with no combinational path from out_ready.
REQ-019 The FSM SHALL have three states: IDLE (term_cnt=0), ACC (0<term_cnt<ACC_LEN), and FULL (buffer holds 2 entries).
REQ-020 Transitions: IDLE->ACC on an accepted product; ACC->IDLE on the ACC_LEN-th accepted product; any state->FULL when a push leaves 2 entries; FULL->IDLE or FULL->ACC (matching term_cnt) when a pop occurs.
REQ-021 On the ACC_LEN-th accepted product, the block SHALL form S = acc + masked P in the same cycle and push round_sat(S) to the buffer on that edge.
REQ-022 On that same edge, the accumulator and term_cnt SHALL clear to 0.
REQ-023 round_sat(S) SHALL compute (S + 2^(SHIFT-1)) arithmetically shifted right by SHIFT.
REQ-024 round_sat(S) SHALL clamp the result to [-2^(OUT_BITWIDTH-1), 2^(OUT_BITWIDTH-1)-1]; sat_flag SHALL set on any clamp.
REQ-025 Latency SHALL be 1 cycle: out_valid rises on the cycle after the final product is accepted if the buffer was empty.
REQ-026 The output buffer SHALL be a 2-entry FIFO that preserves order.
REQ-027 A push and a pop in the same cycle SHALL leave the FIFO entry count unchanged.
REQ-028 A pop on an empty FIFO SHALL be a no-op.
REQ-029 flush SHALL clear the accumulator and term_cnt on the next edge and SHALL NOT affect buffered results or sat_flag.
REQ-030 When flush coincides with an accepted product, flush SHALL win on the old sum, and the product SHALL become term 1 of a new sum (term_cnt=1, acc=masked P).
REQ-031 When flush coincides with the ACC_LEN-th product, no result SHALL be pushed, and term_cnt SHALL become 1.
REQ-032 The block SHALL ignore state/count encodings from upstream and SHALL rely only on p_valid.

Reset
REQ-033 On racc=1, asynchronously: accumulator=0, term_cnt=0, FIFO empty, out_valid=0, out_data=0, in_ready=1, sat_flag=0, FSM=IDLE.
REQ-034 Reset asserted mid-accumulation or with buffered data SHALL discard all data; no output SHALL emerge after release.
REQ-035 The first product SHALL be accepted on the first posedge clk after racc deasserts.

Verification
REQ-036 Scenario: 8 consecutive products P=0x00010000, rapx=0, out_ready=1 -> one output out_data=8, out_valid high for exactly 1 cycle, 1 cycle after the 8th product.
REQ-037 Scenario: 8 products P=0x7FFFFFFF -> out_data=0x7FFF, sat_flag=1; then 8 products P=0x80000000 -> out_data=0x8000.
REQ-038 Scenario: rapx=1, 8 products P=0x000000FF -> out_data=0; rounding check: sum=0x8000 -> out_data=1.
REQ-039 Scenario: out_ready=0, 24 products -> 2 results buffered, in_ready=0 after the 16th product, products 17-24 ignored until a pop; then out_ready=1 -> results drain in order and in_ready returns to 1.
REQ-040 Scenario: flush with the 5th product, then 7 more products -> exactly one output equal to the sum of products 5-12 only.
REQ-041 Scenario: racc pulse after the 3rd product, with 1 result buffered -> out_valid=0 immediately, term_cnt=0; 8 new products -> one correct output.

Source files
------------

// File: rtl/idct_row_accum.sv
// idct_row_accum
//   Accumulates ACC_LEN signed products from the multiplier-wrapper stage into
//   one IDCT row sample. The sample is rounded and shifted right by SHIFT, then
//   saturated to OUT_BITWIDTH bits. Finished samples wait in a 2-entry FIFO
//   until the downstream stage takes them.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   racc       asynchronous active-high reset
//   P          signed 32-bit product
//   p_valid    P holds a product this cycle
//   rapx       approximate mode: P[7:0] is treated as zero
//   flush      drops the partial sum and term count on the next edge
//   in_ready   a product is accepted this cycle (registered)
//   out_data   signed head entry of the output FIFO
//   out_valid  out_data is valid
//   out_ready  downstream takes out_data when out_valid is 1
//   term_cnt   number of terms in the current partial sum
//   sat_flag   sticky; set once any output sample was clamped
module idct_row_accum #(
  parameter int ACC_LEN      = 8,
  parameter int OUT_BITWIDTH = 16,
  parameter int SHIFT        = 16
) (
  input  logic                            clk,
  input  logic                            racc,
  input  logic signed [31:0]              P,
  input  logic                            p_valid,
  input  logic                            rapx,
  input  logic                            flush,
  output logic                            in_ready,
  output logic signed [OUT_BITWIDTH-1:0]  out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(ACC_LEN):0]        term_cnt,
  output logic                            sat_flag
);

  localparam int LOG_LEN = $clog2(ACC_LEN);
  localparam int CNT_W   = LOG_LEN + 1;
  localparam int ACC_W   = 32 + LOG_LEN + 1;
  // One extra bit so that adding the rounding constant can never wrap.
  localparam int RND_W   = ACC_W + 1;

  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (SHIFT - 1);
  localparam logic signed [RND_W-1:0] OUT_MAX  = (RND_W'(1) << (OUT_BITWIDTH - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] OUT_MIN  = -(RND_W'(1) << (OUT_BITWIDTH - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FULL = 2'd2
  } state_t;

  // Round half up, then arithmetic shift.
  function automatic logic signed [RND_W-1:0] round_shift(input logic signed [ACC_W-1:0] s);
    logic signed [RND_W-1:0] t;
    t = $signed({s[ACC_W-1], s}) + RND_HALF;
    return t >>> SHIFT;
  endfunction

  function automatic logic is_clamped(input logic signed [RND_W-1:0] r);
    return (r > OUT_MAX) || (r < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_BITWIDTH-1:0] saturate(input logic signed [RND_W-1:0] r);
    logic signed [OUT_BITWIDTH-1:0] q;
    if (r > OUT_MAX)      q = OUT_MAX[OUT_BITWIDTH-1:0];
    else if (r < OUT_MIN) q = OUT_MIN[OUT_BITWIDTH-1:0];
    else                  q = r[OUT_BITWIDTH-1:0];
    return q;
  endfunction

  state_t                          state_p1, state_nxt;
  logic signed [ACC_W-1:0]         acc_p1, acc_nxt;
  logic [CNT_W-1:0]                cnt_nxt;
  logic [1:0]                      fifo_cnt_p1, fifo_cnt_nxt;
  logic signed [OUT_BITWIDTH-1:0]  ent0_p1, ent0_nxt;
  logic signed [OUT_BITWIDTH-1:0]  ent1_p1, ent1_nxt;

  logic                            accept, last_term, push, pop;
  logic signed [31:0]              p_mask;
  logic signed [ACC_W-1:0]         p_ext, sum;
  logic signed [RND_W-1:0]         rnd;
  logic signed [OUT_BITWIDTH-1:0]  res;
  logic                            clamp;

  assign p_mask = rapx ? $signed({P[31:8], 8'h00}) : P;
  assign p_ext  = $signed({{(ACC_W-32){p_mask[31]}}, p_mask});
  assign sum    = acc_p1 + p_ext;
  assign rnd    = round_shift(sum);
  assign res    = saturate(rnd);
  assign clamp  = is_clamped(rnd);

  // in_ready is decoded from the state register only, so out_ready never
  // reaches it combinationally; a freed slot shows up one cycle after the pop.
  assign in_ready  = (state_p1 != FULL);
  assign out_valid = (fifo_cnt_p1 != 2'd0);
  assign out_data  = ent0_p1;

  always_comb begin
    accept    = p_valid && in_ready;
    last_term = (term_cnt == CNT_W'(ACC_LEN - 1));
    // A flush on the final term discards the sum, so nothing is pushed.
    push      = accept && last_term && !flush;
    pop       = out_ready && (fifo_cnt_p1 != 2'd0);

    acc_nxt = acc_p1;
    cnt_nxt = term_cnt;
    if (flush) begin
      // The coincident product starts a fresh sum as term 1.
      if (accept) begin
        acc_nxt = p_ext;
        cnt_nxt = CNT_W'(1);
      end else begin
        acc_nxt = '0;
        cnt_nxt = '0;
      end
    end else if (accept) begin
      if (last_term) begin
        acc_nxt = '0;
        cnt_nxt = '0;
      end else begin
        acc_nxt = sum;
        cnt_nxt = term_cnt + CNT_W'(1);
      end
    end

    // Two-entry FIFO with ent0 always the head; a pop shifts ent1 forward.
    fifo_cnt_nxt = fifo_cnt_p1;
    ent0_nxt     = ent0_p1;
    ent1_nxt     = ent1_p1;
    case ({push, pop})
      2'b10: begin
        if (fifo_cnt_p1 == 2'd0) ent0_nxt = res;
        else                     ent1_nxt = res;
        fifo_cnt_nxt = fifo_cnt_p1 + 2'd1;
      end
      2'b01: begin
        ent0_nxt     = ent1_p1;
        fifo_cnt_nxt = fifo_cnt_p1 - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_p1 == 2'd1) begin
          ent0_nxt = res;
        end else begin
          ent0_nxt = ent1_p1;
          ent1_nxt = res;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state_p1;
    if (fifo_cnt_nxt == 2'd2)  state_nxt = FULL;
    else if (cnt_nxt == '0)    state_nxt = IDLE;
    else                       state_nxt = ACC;
  end

  // ---- stage p1: accumulator, control and FIFO head ----
  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      state_p1    <= IDLE;
      acc_p1      <= '0;
      term_cnt    <= '0;
      fifo_cnt_p1 <= 2'd0;
      ent0_p1     <= '0;
      sat_flag    <= 1'b0;
    end else begin
      state_p1    <= state_nxt;
      acc_p1      <= acc_nxt;
      term_cnt    <= cnt_nxt;
      fifo_cnt_p1 <= fifo_cnt_nxt;
      ent0_p1     <= ent0_nxt;
      if (push && clamp) sat_flag <= 1'b1;
    end
  end

  // Second FIFO slot is only read when fifo_cnt_p1 says it is occupied.
  always_ff @(posedge clk) begin
    ent1_p1 <= ent1_nxt;
  end

endmodule

// File: tb/tb_idct_row_accum.sv
// tb_idct_row_accum
//   Directed-vector bench for idct_row_accum with hand-computed expected
//   results: single sample, saturation, rapx masking, rounding, back-pressure,
//   flush interaction and reset mid-stream.
module tb_idct_row_accum;

  logic        clk = 1'b0;
  logic        racc;
  logic [31:0] P;
  logic        p_valid;
  logic        rapx;
  logic        flush;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  term_cnt;
  logic        sat_flag;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  idct_row_accum #(
    .ACC_LEN(8),
    .OUT_BITWIDTH(16),
    .SHIFT(16)
  ) dut (
    .clk(clk),
    .racc(racc),
    .P(P),
    .p_valid(p_valid),
    .rapx(rapx),
    .flush(flush),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .term_cnt(term_cnt),
    .sat_flag(sat_flag)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one product and hold it until the block takes it.
  task automatic send(input logic [31:0] p, input logic fl);
    int n;
    n = 0;
    P = p;
    flush = fl;
    p_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    p_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic burst(input logic [31:0] p, input int n);
    for (int i = 0; i < n; i++) send(p, 1'b0);
  endtask

  // Called one unit after a rising edge; releases racc on the falling edge.
  task automatic do_reset(input string tag);
    racc = 1'b1;
    #3;
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"},  out_data,  16'h0000);
    chk({tag, "_in_ready"},  in_ready,  1'b1);
    chk({tag, "_term_cnt"},  term_cnt,  4'd0);
    chk({tag, "_sat_flag"},  sat_flag,  1'b0);
    #1;
    racc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    racc = 1'b1;
    P = 32'h0;
    p_valid = 1'b0;
    rapx = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset("rst0");

    // Basic sample: 8 x 0x10000 -> 8, valid for one cycle.
    out_ready = 1'b1;
    burst(32'h0001_0000, 3);
    chk("basic_cnt3", term_cnt, 4'd3);
    burst(32'h0001_0000, 4);
    chk("basic_novalid7", out_valid, 1'b0);
    burst(32'h0001_0000, 1);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_data", out_data, 16'h0008);
    chk("basic_cnt0", term_cnt, 4'd0);
    @(posedge clk); #1;
    chk("basic_onecycle", out_valid, 1'b0);

    // Saturation both directions.
    burst(32'h7FFF_FFFF, 8);
    chk("sat_pos_data", out_data, 16'h7FFF);
    chk("sat_pos_flag", sat_flag, 1'b1);
    burst(32'h8000_0000, 8);
    chk("sat_neg_data", out_data, 16'h8000);
    chk("sat_sticky", sat_flag, 1'b1);
    @(posedge clk); #1;
    do_reset("rst1");

    // rapx masking and rounding.
    out_ready = 1'b1;
    rapx = 1'b1;
    burst(32'h0000_00FF, 8);
    chk("rapx_ff", out_data, 16'h0000);
    chk("rapx_ff_valid", out_valid, 1'b1);
    // masked sum 0x7F00 rounds to 0; unmasked 0x86F8 rounds to 1
    burst(32'h0000_10FF, 7);
    send(32'h0000_0FFF, 1'b0);
    chk("rapx_mask_on", out_data, 16'h0000);
    rapx = 1'b0;
    burst(32'h0000_10FF, 7);
    send(32'h0000_0FFF, 1'b0);
    chk("rapx_mask_off", out_data, 16'h0001);
    burst(32'h0000_1000, 8);
    chk("round_half", out_data, 16'h0001);
    burst(32'h0000_0FFF, 8);
    chk("round_below", out_data, 16'h0000);
    // -0x40000 + 0x8000 = -3.5 * 2^16 -> floor -4
    burst(32'hFFFF_8000, 8);
    chk("round_neg", out_data, 16'hFFFC);
    chk("round_nosat", sat_flag, 1'b0);
    @(posedge clk); #1;

    // Back-pressure: two results buffered, further products held off.
    out_ready = 1'b0;
    burst(32'h0001_0000, 8);
    burst(32'h0002_0000, 8);
    chk("bp_in_ready0", in_ready, 1'b0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_head", out_data, 16'h0008);
    P = 32'h0003_0000;
    p_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_ignored_cnt", term_cnt, 4'd0);
    chk("bp_still_full", in_ready, 1'b0);
    chk("bp_head_hold", out_data, 16'h0008);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_second", out_data, 16'h0010);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_in_ready1", in_ready, 1'b1);
    chk("bp_cnt_still0", term_cnt, 4'd0);
    @(posedge clk); #1;
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_cnt1", term_cnt, 4'd1);
    repeat (7) begin @(posedge clk); #1; end
    p_valid = 1'b0;
    chk("bp_third_valid", out_valid, 1'b1);
    chk("bp_third", out_data, 16'h0018);
    chk("bp_ready_back", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 1'b0);

    // Flush with the 5th product: output is products 5..12 only.
    burst(32'h0001_0000, 4);
    send(32'h0002_0000, 1'b1);
    chk("flush_cnt1", term_cnt, 4'd1);
    burst(32'h0002_0000, 3);
    chk("flush_no_old", out_valid, 1'b0);
    burst(32'h0002_0000, 4);
    chk("flush_valid", out_valid, 1'b1);
    chk("flush_data", out_data, 16'h0010);
    @(posedge clk); #1;
    // Flush alone, then flush together with the 8th product.
    burst(32'h0001_0000, 3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_alone", term_cnt, 4'd0);
    burst(32'h0001_0000, 7);
    send(32'h0001_0000, 1'b1);
    chk("flush8_nopush", out_valid, 1'b0);
    chk("flush8_cnt1", term_cnt, 4'd1);
    burst(32'h0001_0000, 7);
    chk("flush8_after", out_data, 16'h0008);
    chk("flush8_after_valid", out_valid, 1'b1);
    @(posedge clk); #1;

    // Reset mid-accumulation with a buffered result.
    out_ready = 1'b0;
    burst(32'h0001_0000, 8);
    burst(32'h0001_0000, 3);
    chk("mid_cnt3", term_cnt, 4'd3);
    chk("mid_buffered", out_valid, 1'b1);
    do_reset("rst2");
    out_ready = 1'b1;
    send(32'h0002_0000, 1'b0);
    chk("post_rst_first", term_cnt, 4'd1);
    chk("post_rst_nodata", out_valid, 1'b0);
    burst(32'h0002_0000, 7);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_data", out_data, 16'h0010);
    @(posedge clk); #1;
    chk("post_rst_pop", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
